scroll_offset_gen: RTL and testbench
====================================

// Module: scroll_offset_gen
// PURPOSE
// - Consumes the slow divided clock produced by the clock divider (clk_out, ~2 Hz toggle from 50 MHz)
//   and turns it into a scrolling pixel offset for the VGA pattern renderer.
// - Treats shift_clk as asynchronous data: synchronises it, edge-detects it, then steps a wrapping
//   offset counter entirely in the clk_in domain.
// - Never uses shift_clk as a clock; sits between the divider and the pixel/pattern generator.
// PARAMETERS
// - WIDTH       10   offset width in bits
// - MAX_OFFSET  639  largest offset value; the counter wraps modulo MAX_OFFSET+1; must be < 2**WIDTH
// - STEP        1    offset increment per step; 1 <= STEP <= MAX_OFFSET
// PORTS
// - clk_in      in   1      system clock (50 MHz)
// - rst_n       in   1      asynchronous active-low reset
// - shift_clk   in   1      slow toggle from clock divider; async to clk_in
// - enable      in   1      1 = stepping allowed
// - dir         in   1      0 = offset increases, 1 = offset decreases
// - load        in   1      synchronous load strobe
// - load_value  in   WIDTH  value applied on load
// - offset      out  WIDTH  current scroll offset
// - step_pulse  out  1      1-cycle pulse in the cycle offset changes due to a step
// - wrap        out  1      1-cycle pulse coincident with a step_pulse that wrapped
// BEHAVIOUR
// - Reset: sync1, sync2, prev = 0; offset = 0; step_pulse = 0; wrap = 0; state = IDLE.
// - Sync: 2-flop synchroniser (sync1 -> sync2); prev <= sync2; rise = sync2 & ~prev.
// - Latency: offset and step_pulse update on the 3rd clk_in rising edge after a shift_clk rise,
//   assuming setup at the first flop.
// - FSM:
//   - IDLE:  enable=0; no stepping. enable=1 -> ARMED.
//   - ARMED: swallows the first rise, so a partial divider period is never counted.
//            rise -> RUN. enable=0 -> IDLE.
//   - RUN:   each rise performs one step. enable=0 -> IDLE.
//   - Exit from any state to IDLE takes effect the same cycle enable is sampled low;
//     a rise in that cycle is ignored.
// - Step, up (dir=0):
//   - nxt = offset + STEP, computed in WIDTH+1 bits.
//   - nxt > MAX_OFFSET -> offset = nxt - (MAX_OFFSET+1), wrap = 1.
// - Step, down (dir=1):
//   - offset < STEP -> offset = offset + MAX_OFFSET + 1 - STEP, wrap = 1.
//   - else offset = offset - STEP.
// - dir is sampled in the step cycle; changing it between steps is legal.
// - Load:
//   - load=1 sets offset = min(load_value, MAX_OFFSET) next cycle, in any state.
//   - Load has priority over a simultaneous step: the step is dropped and step_pulse/wrap stay 0.
//   - Load does not change FSM state.
// - step_pulse and wrap are registered; both are 0 in every cycle without a step.
// - rst_n asserted mid-operation: all state clears immediately (async).
//   After release, the block is in IDLE and needs enable + ARMED before the next step.
// CONFIGURATION
// - BOTH_EDGES_EN defined:
//   - The step trigger is sync2 ^ prev, so both shift_clk edges step (2x rate).
//   - ARMED swallows the first edge of either polarity.
// - BOTH_EDGES_EN undefined: rising edges only, as above.
// TESTING
// - Reset: hold rst_n=0 with shift_clk toggling -> offset=0, step_pulse=0, wrap=0 throughout.
// - Arm/run, up: enable=1, dir=0, 4 shift_clk rises ->
//   first rise swallowed, then offset 0 -> 1 -> 2 -> 3, one step_pulse each, 3 cycles after each rise.
// - Up wrap: load 638, RUN, 2 rises -> offset 639, then 0; wrap=1 only on the second step.
//   With STEP=3: load 638 then 1 rise -> offset 1, wrap=1.
// - Down wrap: dir=1, load 0, 1 rise in RUN -> offset 639 (STEP=1), wrap=1.
// - Load vs step collision: load=1, load_value=700, in the same cycle as the step ->
//   offset=639 (clamped), step_pulse=0; the next rise steps normally.
// - Disable/reset mid-run: enable=0 -> no further steps; re-enable needs a swallowed rise.
//   rst_n pulse mid-run -> offset=0 asynchronously, FSM in IDLE.
//   Repeat the arm/run scenario with BOTH_EDGES_EN: 4 edges -> 3 steps.

Source files
------------

// File: rtl/scroll_offset_gen.sv
// Scroll offset generator: synchronises the slow divider toggle and steps a wrapping pixel offset.
// Build option BOTH_EDGES_EN: step on both shift_clk edges instead of rising edges only.
module scroll_offset_gen #(
    parameter int WIDTH      = 10,
    parameter int MAX_OFFSET = 639,
    parameter int STEP       = 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             shift_clk,
    input  logic             enable,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] offset,
    output logic             step_pulse,
    output logic             wrap
);

    // state | meaning
    // IDLE  | stepping disabled
    // ARMED | enabled, waiting to swallow the first (possibly partial) divider edge
    // RUN   | every detected edge performs one step
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [WIDTH:0]   MAX_W     = (WIDTH+1)'(MAX_OFFSET);
    localparam logic [WIDTH:0]   ONE_W     = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MAXP1_W   = MAX_W + ONE_W;
    localparam logic [WIDTH:0]   WRAP_DN_W = MAXP1_W - STEP_W;
    localparam logic [WIDTH-1:0] MAX_N     = WIDTH'(MAX_OFFSET);

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0]  offset_q, offset_d;
    logic              step_pulse_q, step_pulse_d;
    logic              wrap_q, wrap_d;
    logic              trig;
    logic              step_en;
    logic [WIDTH:0]    offset_ext;
    logic [WIDTH:0]    sum_up;
    logic [WIDTH-1:0]  step_val;
    logic              step_wrap;
    logic [WIDTH-1:0]  load_clamped;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= shift_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

`ifdef BOTH_EDGES_EN
    assign trig = sync2_q ^ prev_q;
`else
    assign trig = sync2_q & ~prev_q;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping enable wins over any edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (trig) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        step_en = (state_q == RUN) && enable && trig;
    end

    always_comb begin
        offset_ext = {1'b0, offset_q};
        sum_up     = offset_ext + STEP_W;
        step_val   = offset_q;
        step_wrap  = 1'b0;
        if (!dir) begin
            if (sum_up > MAX_W) begin
                step_val  = WIDTH'(sum_up - MAXP1_W);
                step_wrap = 1'b1;
            end else begin
                step_val  = WIDTH'(sum_up);
            end
        end else begin
            if (offset_ext < STEP_W) begin
                step_val  = WIDTH'(offset_ext + WRAP_DN_W);
                step_wrap = 1'b1;
            end else begin
                step_val  = WIDTH'(offset_ext - STEP_W);
            end
        end
    end

    always_comb begin
        load_clamped = (load_value > MAX_N) ? MAX_N : load_value;
        offset_d     = offset_q;
        step_pulse_d = 1'b0;
        wrap_d       = 1'b0;
        if (load) begin
            offset_d = load_clamped;
        end else if (step_en) begin
            offset_d     = step_val;
            step_pulse_d = 1'b1;
            wrap_d       = step_wrap;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            offset_q     <= '0;
            step_pulse_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            offset_q     <= offset_d;
            step_pulse_q <= step_pulse_d;
            wrap_q       <= wrap_d;
        end
    end

    assign offset     = offset_q;
    assign step_pulse = step_pulse_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_scroll_offset_gen.sv
// Directed bench for scroll_offset_gen: one STEP=1 instance and one STEP=3 instance share stimulus.
module tb_scroll_offset_gen;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       shift_clk;
    logic       enable;
    logic       dir;
    logic       load;
    logic [9:0] load_value;
    logic [9:0] offset, offset3;
    logic       step_pulse, step_pulse3;
    logic       wrap, wrap3;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_in = ~clk_in;

    scroll_offset_gen #(.WIDTH(10), .MAX_OFFSET(639), .STEP(1)) u_dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .shift_clk  (shift_clk),
        .enable     (enable),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .offset     (offset),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    scroll_offset_gen #(.WIDTH(10), .MAX_OFFSET(639), .STEP(3)) u_dut3 (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .shift_clk  (shift_clk),
        .enable     (enable),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .offset     (offset3),
        .step_pulse (step_pulse3),
        .wrap       (wrap3)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Drive one shift_clk edge and check the result three clk_in edges later.
    task automatic edge_step(input logic val, input string tag,
                             input int e_off, input int e_pulse, input int e_wrap,
                             input int e3_off, input int e3_wrap, input bit ld_col);
        shift_clk = val;
        tick(2);
        chk({tag, ".pre_pulse"}, int'(step_pulse), 0);
        if (ld_col) begin
            load       = 1'b1;
            load_value = 10'd700;
        end
        tick(1);
        load = 1'b0;
        chk({tag, ".off"},    int'(offset),      e_off);
        chk({tag, ".pulse"},  int'(step_pulse),  e_pulse);
        chk({tag, ".wrap"},   int'(wrap),        e_wrap);
        chk({tag, ".off3"},   int'(offset3),     e3_off);
        chk({tag, ".pulse3"}, int'(step_pulse3), e_pulse);
        chk({tag, ".wrap3"},  int'(wrap3),       e3_wrap);
        tick(1);
        chk({tag, ".post_pulse"}, int'(step_pulse) + int'(step_pulse3), 0);
        tick(1);
    endtask

    task automatic do_load(input logic [9:0] v);
        load       = 1'b1;
        load_value = v;
        tick(1);
        load = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        shift_clk  = 1'b0;
        enable     = 1'b0;
        dir        = 1'b0;
        load       = 1'b0;
        load_value = '0;

        for (int i = 0; i < 6; i++) begin
            shift_clk = ~shift_clk;
            tick(2);
            chk("rst.off",   int'(offset) + int'(offset3), 0);
            chk("rst.pulse", int'(step_pulse) + int'(step_pulse3), 0);
            chk("rst.wrap",  int'(wrap) + int'(wrap3), 0);
        end
        shift_clk = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        chk("idle.off", int'(offset), 0);

        enable = 1'b1;
        tick(2);
`ifdef BOTH_EDGES_EN
        edge_step(1'b1, "arm.e1", 0, 0, 0, 0, 0, 1'b0);
        edge_step(1'b0, "arm.e2", 1, 1, 0, 3, 0, 1'b0);
        edge_step(1'b1, "arm.e3", 2, 1, 0, 6, 0, 1'b0);
        edge_step(1'b0, "arm.e4", 3, 1, 0, 9, 0, 1'b0);
`else
        edge_step(1'b1, "arm.r1", 0, 0, 0, 0, 0, 1'b0);
        edge_step(1'b0, "arm.f1", 0, 0, 0, 0, 0, 1'b0);
        edge_step(1'b1, "arm.r2", 1, 1, 0, 3, 0, 1'b0);
        edge_step(1'b0, "arm.f2", 1, 0, 0, 3, 0, 1'b0);
        edge_step(1'b1, "arm.r3", 2, 1, 0, 6, 0, 1'b0);
        edge_step(1'b0, "arm.f3", 2, 0, 0, 6, 0, 1'b0);
        edge_step(1'b1, "arm.r4", 3, 1, 0, 9, 0, 1'b0);
        edge_step(1'b0, "arm.f4", 3, 0, 0, 9, 0, 1'b0);

        do_load(10'd638);
        chk("load.off",  int'(offset),  638);
        chk("load.off3", int'(offset3), 638);
        edge_step(1'b1, "upwrap.r1", 639, 1, 0, 1, 1, 1'b0);
        edge_step(1'b0, "upwrap.f1", 639, 0, 0, 1, 0, 1'b0);
        edge_step(1'b1, "upwrap.r2",   0, 1, 1, 4, 0, 1'b0);
        edge_step(1'b0, "upwrap.f2",   0, 0, 0, 4, 0, 1'b0);

        dir = 1'b1;
        do_load(10'd0);
        edge_step(1'b1, "dnwrap.r1", 639, 1, 1, 637, 1, 1'b0);
        edge_step(1'b0, "dnwrap.f1", 639, 0, 0, 637, 0, 1'b0);
        edge_step(1'b1, "down.r2",   638, 1, 0, 634, 0, 1'b0);
        edge_step(1'b0, "down.f2",   638, 0, 0, 634, 0, 1'b0);

        edge_step(1'b1, "collide.r", 639, 0, 0, 639, 0, 1'b1);
        edge_step(1'b0, "collide.f", 639, 0, 0, 639, 0, 1'b0);
        dir = 1'b0;
        edge_step(1'b1, "after_col.r", 0, 1, 1, 2, 1, 1'b0);
        edge_step(1'b0, "after_col.f", 0, 0, 0, 2, 0, 1'b0);

        enable = 1'b0;
        tick(1);
        edge_step(1'b1, "dis.r", 0, 0, 0, 2, 0, 1'b0);
        edge_step(1'b0, "dis.f", 0, 0, 0, 2, 0, 1'b0);
        enable = 1'b1;
        tick(2);
        edge_step(1'b1, "rearm.r1", 0, 0, 0, 2, 0, 1'b0);
        edge_step(1'b0, "rearm.f1", 0, 0, 0, 2, 0, 1'b0);
        edge_step(1'b1, "rearm.r2", 1, 1, 0, 5, 0, 1'b0);
        edge_step(1'b0, "rearm.f2", 1, 0, 0, 5, 0, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.off",  int'(offset),  0);
        chk("async_rst.off3", int'(offset3), 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        edge_step(1'b1, "post_rst.r1", 0, 0, 0, 0, 0, 1'b0);
        edge_step(1'b0, "post_rst.f1", 0, 0, 0, 0, 0, 1'b0);
        edge_step(1'b1, "post_rst.r2", 1, 1, 0, 3, 0, 1'b0);
        edge_step(1'b0, "post_rst.f2", 1, 0, 0, 3, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
